// File: rtl/plaintext_pkg.sv
// rtl/plaintext_pkg.sv - shared constants and lane helper for the plaintext word packer
package plaintext_pkg;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W          = 3;
   localparam int WORD_W_DEF     = 32;
   localparam int ENTRY_W        = WORD_W_DEF + CNT_W;

   // Byte n of a word lands in lane 3-n so the first byte ends up in the top lane.
   function automatic logic [1:0] lane_idx(input logic [1:0] byte_cnt);
      return 2'd3 - byte_cnt;
   endfunction
endpackage

// File: rtl/plaintext_word_packer_if.sv
// rtl/plaintext_word_packer_if.sv - byte input stream and word output handshake of the packer
interface plaintext_word_packer_if #(
   parameter int SYS_DWIDTH = 8,
   parameter int MST_DWIDTH = 32
) ();
   import plaintext_pkg::*;

   logic [SYS_DWIDTH-1:0] data_i;
   logic                  valid_i;
   logic [MST_DWIDTH-1:0] word_o;
   logic [CNT_W-1:0]      bytes_o;
   logic                  valid_o;
   logic                  ready_i;

   modport master (
      output data_i, valid_i, ready_i,
      input  word_o, bytes_o, valid_o
   );

   modport slave (
      input  data_i, valid_i, ready_i,
      output word_o, bytes_o, valid_o
   );
endinterface

// File: rtl/plaintext_fifo.sv
// rtl/plaintext_fifo.sv - synchronous first-word-fall-through FIFO over registered storage
module plaintext_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == LW'(DEPTH));
   assign level    = count;
   assign pop_data = mem[rd_ptr];

   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + LW'(1);
         end else if (!do_push && do_pop) begin
            count <= count - LW'(1);
         end
      end
   end
endmodule

// File: rtl/plaintext_word_packer.sv
// rtl/plaintext_word_packer.sv - packs plaintext bytes MSB-first into words, flushes partials on busy fall
module plaintext_word_packer
   import plaintext_pkg::*;
#(
   parameter int SYS_DWIDTH = 8,
   parameter int MST_DWIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   plaintext_word_packer_if.slave bus,
   input  logic                  busy_i,
   output logic [LW-1:0]         level_o,
   output logic                  overflow,
   input  logic                  clear_i
);
   localparam int EW = MST_DWIDTH + CNT_W;

   logic [1:0]            byte_cnt;
   logic [MST_DWIDTH-1:0] pack_q;
   logic [MST_DWIDTH-1:0] pack_next;
   logic                  busy_q;
   logic                  busy_fall;
   logic [CNT_W-1:0]      eff_cnt;
   logic                  push;
   logic [CNT_W-1:0]      push_bytes;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [EW-1:0]         head;

   assign busy_fall = busy_q && !busy_i;
   assign eff_cnt   = {1'b0, byte_cnt} + {2'b00, bus.valid_i};

   always_comb begin
      pack_next = pack_q;
      if (bus.valid_i) begin
         pack_next[int'(lane_idx(byte_cnt)) * SYS_DWIDTH +: SYS_DWIDTH] = bus.data_i;
      end
   end

   // A byte completing the word wins over the flush, so only one entry is ever pushed.
   always_comb begin
      push       = 1'b0;
      push_bytes = '0;
      if (bus.valid_i && byte_cnt == 2'd3) begin
         push       = 1'b1;
         push_bytes = CNT_W'(BYTES_PER_WORD);
      end else if (busy_fall && eff_cnt != '0) begin
         push       = 1'b1;
         push_bytes = eff_cnt;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         byte_cnt <= '0;
         pack_q   <= '0;
         busy_q   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         busy_q <= busy_i;
         if (push) begin
            byte_cnt <= '0;
            pack_q   <= '0;
         end else if (bus.valid_i) begin
            byte_cnt <= byte_cnt + 2'd1;
            pack_q   <= pack_next;
         end
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end else if (clear_i) begin
            overflow <= 1'b0;
         end
      end
   end

   assign pop = bus.valid_o && bus.ready_i;

   plaintext_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_sys),
      .rst       (rst),
      .push      (push),
      .push_data ({pack_next, push_bytes}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level_o)
   );

   assign bus.word_o  = head[EW-1:CNT_W];
   assign bus.bytes_o = head[CNT_W-1:0];
   assign bus.valid_o = !fifo_empty;
endmodule

// File: tb/tb_plaintext_word_packer.sv
// tb/tb_plaintext_word_packer.sv - randomized and directed bench with a queue-based reference model
module tb_plaintext_word_packer;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] w;
      int          n;
   } ent_t;

   logic       clk_sys = 1'b0;
   logic       rst;
   logic       busy_i;
   logic       clear_i;
   logic [2:0] level_o;
   logic       overflow;

   plaintext_word_packer_if #(.SYS_DWIDTH(8), .MST_DWIDTH(32)) pk_if ();

   plaintext_word_packer #(
      .SYS_DWIDTH (8),
      .MST_DWIDTH (32),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .bus      (pk_if.slave),
      .busy_i   (busy_i),
      .level_o  (level_o),
      .overflow (overflow),
      .clear_i  (clear_i)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_pass   = 0;

   ent_t       mq[$];
   logic [7:0] pend[$];
   logic       m_busy_prev = 1'b0;
   logic       m_ovf       = 1'b0;
   logic [7:0] seq_byte    = 8'h00;
   logic       rnd_busy    = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack_bytes(input logic [7:0] b[$]);
      logic [31:0] w = '0;
      foreach (b[i]) begin
         w = w | ({24'h0, b[i]} << (8 * (3 - i)));
      end
      return w;
   endfunction

   task automatic model_edge(input logic [7:0] d, input logic v, input logic b,
                             input logic r, input logic c, input logic rs);
      ent_t e;
      logic push = 1'b0;
      if (rs) begin
         mq.delete();
         pend.delete();
         m_busy_prev = 1'b0;
         m_ovf       = 1'b0;
      end else begin
         if (v) pend.push_back(d);
         if (pend.size() == 4 || (m_busy_prev && !b && pend.size() != 0)) begin
            e.w  = pack_bytes(pend);
            e.n  = pend.size();
            push = 1'b1;
            pend.delete();
         end
         if (mq.size() != 0 && r) void'(mq.pop_front());
         if (push && mq.size() >= DEPTH) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
         if (push && mq.size() < DEPTH) mq.push_back(e);
         m_busy_prev = b;
      end
   endtask

   task automatic model_compare();
      chk("valid_o", pk_if.valid_o, mq.size() != 0);
      chk("level_o", level_o, mq.size());
      chk("overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
         chk("word_o", pk_if.word_o, mq[0].w);
         chk("bytes_o", pk_if.bytes_o, mq[0].n);
      end
   endtask

   task automatic step(input logic [7:0] d, input logic v, input logic b,
                       input logic r, input logic c, input logic rs);
      pk_if.data_i  = d;
      pk_if.valid_i = v;
      pk_if.ready_i = r;
      busy_i        = b;
      clear_i       = c;
      rst           = rs;
      @(posedge clk_sys);
      model_edge(d, v, b, r, c, rs);
      @(negedge clk_sys);
      model_compare();
   endtask

   task automatic send(input logic [7:0] d, input logic b, input logic r, input logic c);
      step(d, 1'b1, b, r, c, 1'b0);
   endtask

   task automatic idle(input logic b, input logic r);
      step(8'h00, 1'b0, b, r, 1'b0, 1'b0);
   endtask

   task automatic send_seq(input int n, input logic r);
      for (int i = 0; i < n; i++) begin
         seq_byte = seq_byte + 8'd1;
         send(seq_byte, 1'b0, r, 1'b0);
      end
   endtask

   initial begin
      pk_if.data_i  = '0;
      pk_if.valid_i = 1'b0;
      pk_if.ready_i = 1'b0;
      busy_i        = 1'b0;
      clear_i       = 1'b0;
      rst           = 1'b1;
      @(negedge clk_sys);
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset word_o", pk_if.word_o, 32'h0);
      chk("reset bytes_o", pk_if.bytes_o, 3'd0);

      // full word on consecutive cycles
      send(8'h41, 1'b0, 1'b1, 1'b0);
      send(8'h42, 1'b0, 1'b1, 1'b0);
      send(8'h43, 1'b0, 1'b1, 1'b0);
      send(8'h44, 1'b0, 1'b1, 1'b0);
      chk("word4 valid", pk_if.valid_o, 1'b1);
      chk("word4 data", pk_if.word_o, 32'h41424344);
      chk("word4 bytes", pk_if.bytes_o, 3'd4);
      idle(1'b0, 1'b1);
      chk("word4 drained", pk_if.valid_o, 1'b0);

      // partial flush, then a falling edge with nothing pending
      idle(1'b1, 1'b0);
      send(8'h61, 1'b1, 1'b0, 1'b0);
      send(8'h62, 1'b1, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      chk("flush2 data", pk_if.word_o, 32'h61620000);
      chk("flush2 bytes", pk_if.bytes_o, 3'd2);
      idle(1'b0, 1'b1);
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      chk("empty flush", level_o, 3'd0);

      // same-cycle byte on falling edge with three pending
      idle(1'b1, 1'b0);
      send(8'h01, 1'b1, 1'b0, 1'b0);
      send(8'h02, 1'b1, 1'b0, 1'b0);
      send(8'h03, 1'b1, 1'b0, 1'b0);
      send(8'h7A, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      chk("fall+byte3 level", level_o, 3'd1);
      chk("fall+byte3 data", pk_if.word_o, 32'h0102037A);
      idle(1'b0, 1'b1);

      // same-cycle byte on falling edge with one pending
      idle(1'b1, 1'b0);
      send(8'h11, 1'b1, 1'b0, 1'b0);
      send(8'h7A, 1'b0, 1'b0, 1'b0);
      chk("fall+byte1 bytes", pk_if.bytes_o, 3'd2);
      chk("fall+byte1 lane", pk_if.word_o[23:16], 8'h7A);
      idle(1'b0, 1'b1);

      // overflow with no consumer
      send_seq(20, 1'b0);
      chk("ovf level", level_o, 3'd4);
      chk("ovf set", overflow, 1'b1);
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovf cleared", overflow, 1'b0);
      send_seq(3, 1'b0);
      seq_byte = seq_byte + 8'd1;
      send(seq_byte, 1'b0, 1'b0, 1'b1);
      chk("ovf set beats clear", overflow, 1'b1);

      // push and pop together at full
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_seq(3, 1'b0);
      seq_byte = seq_byte + 8'd1;
      send(seq_byte, 1'b0, 1'b1, 1'b0);
      chk("full push+pop level", level_o, 3'd4);
      chk("full push+pop ovf", overflow, 1'b0);
      repeat (5) idle(1'b0, 1'b1);

      // reset mid-message with words queued
      send_seq(14, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("midrst word_o", pk_if.word_o, 32'h0);
      chk("midrst bytes_o", pk_if.bytes_o, 3'd0);
      chk("midrst level", level_o, 3'd0);
      send(8'h01, 1'b0, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0, 1'b0);
      send(8'h03, 1'b0, 1'b0, 1'b0);
      send(8'h04, 1'b0, 1'b0, 1'b0);
      chk("post-rst word", pk_if.word_o, 32'h01020304);
      chk("post-rst level", level_o, 3'd1);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) rnd_busy = ~rnd_busy;
         step(8'($urandom()), $urandom_range(0, 9) < 6, rnd_busy,
              $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
              $urandom_range(0, 199) == 0);
         if (pk_if.valid_o) chk("bytes nonzero", pk_if.bytes_o != 3'd0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
